// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - reflected Gray to binary converter, combinational plus registered path
// Optional Gray step checker enabled by defining GRAY_TO_BIN_STEPCHK_EN.
module gray_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] b_reg,
    output logic             out_valid,
    output logic             step_err
);

    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] b_reg_q;
    logic             out_valid_q;

    // Running XOR from the MSB down: each bit is the parity of g[WIDTH-1:i].
    always_comb begin
        logic acc;
        bin_d = '0;
        acc   = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc      = acc ^ g[i];
            bin_d[i] = acc;
        end
    end

    assign b = bin_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_reg_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                b_reg_q <= bin_d;
            end
        end
    end

    assign b_reg     = b_reg_q;
    assign out_valid = out_valid_q;

`ifdef GRAY_TO_BIN_STEPCHK_EN
    logic [WIDTH-1:0] g_prev_q;
    logic             have_prev_q;
    logic             step_err_q;
    logic [WIDTH-1:0] diff_d;
    logic             one_step_d;

    // A legal Gray step flips exactly one bit: diff is non-zero and a power of two.
    assign diff_d     = g ^ g_prev_q;
    assign one_step_d = (diff_d != '0) && ((diff_d & (diff_d - WIDTH'(1))) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_prev_q    <= '0;
            have_prev_q <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            step_err_q <= in_valid && have_prev_q && !one_step_d;
            if (in_valid) begin
                g_prev_q    <= g;
                have_prev_q <= 1'b1;
            end
        end
    end

    assign step_err = step_err_q;
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_to_bin.sv
// tb/tb_gray_to_bin.sv - self-checking bench for gray_to_bin (WIDTH=4 and WIDTH=8 instances)
module tb_gray_to_bin;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] g;
    logic [3:0] b;
    logic [3:0] b_reg;
    logic       out_valid;
    logic       step_err;

    logic       in_valid8;
    logic [7:0] g8;
    logic [7:0] b8;
    logic [7:0] b_reg8;
    logic       out_valid8;
    logic       step_err8;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         m_have;
    logic [3:0] m_prev;
    logic [3:0] m_breg;
    logic       m_ov;
    logic       m_se;

    always #5 clk = ~clk;

    gray_to_bin #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .g(g),
        .b(b), .b_reg(b_reg), .out_valid(out_valid), .step_err(step_err)
    );

    gray_to_bin #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .g(g8),
        .b(b8), .b_reg(b_reg8), .out_valid(out_valid8), .step_err(step_err8)
    );

    // The binary value whose Gray encoding v^(v>>1) equals gv.
    function automatic int g2b(input int gv, input int w);
        for (int v = 0; v < (1 << w); v++) begin
            if ((v ^ (v >> 1)) == gv) return v;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_have = 1'b0;
        m_prev = '0;
        m_breg = '0;
        m_ov   = 1'b0;
        m_se   = 1'b0;
    endtask

    // Drive one word at the falling edge, let the rising edge take it, update the model.
    task automatic drive(input logic vld, input logic [3:0] gv);
        @(negedge clk);
        in_valid = vld;
        g        = gv;
        @(posedge clk);
        m_ov = vld;
`ifdef GRAY_TO_BIN_STEPCHK_EN
        m_se = vld && m_have && ($countones(gv ^ m_prev) != 1);
`else
        m_se = 1'b0;
`endif
        if (vld) begin
            m_breg = 4'(g2b(int'(gv), 4));
            m_prev = gv;
            m_have = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        g = 4'b0110;
        #1;
        checks++;
        if (b_reg !== 4'b0000 || out_valid !== 1'b0 || step_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: b_reg=%b out_valid=%b step_err=%b, required 0000/0/0",
                     b_reg, out_valid, step_err);
        end
        checks++;
        if (b !== 4'b0100) begin
            errors++;
            $display("FAIL comb_during_reset: b=%b, required 0100", b);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_comb_exhaustive();
        logic [3:0] tg [6] = '{4'b0000, 4'b0001, 4'b0011, 4'b0110, 4'b1000, 4'b1111};
        logic [3:0] tb [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1111, 4'b1010};
        for (int i = 0; i < 16; i++) begin
            g = 4'(i);
            #1;
            checks++;
            if (b !== 4'(g2b(i, 4))) begin
                errors++;
                $display("FAIL comb_exhaustive: g=%b b=%b, required %b", g, b, 4'(g2b(i, 4)));
            end
        end
        for (int i = 0; i < 6; i++) begin
            g = tg[i];
            #1;
            checks++;
            if (b !== tb[i]) begin
                errors++;
                $display("FAIL comb_vector: g=%b b=%b, required %b", g, b, tb[i]);
            end
        end
    endtask

    task automatic test_registered();
        drive(1'b1, 4'b0110);
        checks++;
        if (b_reg !== 4'b0100 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reg_load: b_reg=%b out_valid=%b, required 0100/1", b_reg, out_valid);
        end
        drive(1'b0, 4'b1111);
        checks++;
        if (b_reg !== 4'b0100 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reg_hold: b_reg=%b out_valid=%b, required 0100/0", b_reg, out_valid);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 4'b1000);
        checks++;
        if (b_reg !== 4'b1111 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_load: b_reg=%b out_valid=%b, required 1111/1", b_reg, out_valid);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (b_reg !== 4'b0000 || out_valid !== 1'b0 || step_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: b_reg=%b out_valid=%b step_err=%b, required 0000/0/0",
                     b_reg, out_valid, step_err);
        end
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_step_check();
        logic [3:0] seq [7] = '{4'b0000, 4'b0001, 4'b0011, 4'b0000, 4'b0100, 4'b1000, 4'b0000};
        logic       exp_se [7];
`ifdef GRAY_TO_BIN_STEPCHK_EN
        exp_se = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_se = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, seq[i]);
            checks++;
            if (step_err !== exp_se[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL step_seq[%0d]: g=%b step_err=%b out_valid=%b, required %b/1",
                         i, seq[i], step_err, out_valid, exp_se[i]);
            end
        end
        drive(1'b1, 4'b0000);
        checks++;
        if (step_err !== m_se) begin
            errors++;
            $display("FAIL step_repeat: step_err=%b, required %b", step_err, m_se);
        end
        drive(1'b0, 4'b1111);
        checks++;
        if (step_err !== 1'b0) begin
            errors++;
            $display("FAIL step_idle: step_err=%b, required 0", step_err);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            logic [3:0] gv;
            logic       vld;
            vld = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) gv = m_prev ^ (4'b0001 << $urandom_range(0, 3));
            else gv = 4'($urandom);
            drive(vld, gv);
            checks++;
            if (b_reg !== m_breg || out_valid !== m_ov || step_err !== m_se) begin
                errors++;
                $display("FAIL random[%0d]: b_reg=%b out_valid=%b step_err=%b, required %b/%b/%b",
                         i, b_reg, out_valid, step_err, m_breg, m_ov, m_se);
            end
            checks++;
            if (b !== 4'(g2b(int'(gv), 4))) begin
                errors++;
                $display("FAIL random_comb[%0d]: g=%b b=%b, required %b", i, gv, b, 4'(g2b(int'(gv), 4)));
            end
        end
    endtask

    task automatic test_width8();
        g8 = 8'h80;
        #1;
        checks++;
        if (b8 !== 8'hFF) begin
            errors++;
            $display("FAIL w8_msb: b=%h, required ff", b8);
        end
        g8 = 8'hC0;
        #1;
        checks++;
        if (b8 !== 8'h80) begin
            errors++;
            $display("FAIL w8_c0: b=%h, required 80", b8);
        end
        for (int i = 0; i < 40; i++) begin
            g8 = 8'($urandom);
            #1;
            checks++;
            if (b8 !== 8'(g2b(int'(g8), 8))) begin
                errors++;
                $display("FAIL w8_random: g=%h b=%h, required %h", g8, b8, 8'(g2b(int'(g8), 8)));
            end
        end
        checks++;
        if (b_reg8 !== 8'h00 || out_valid8 !== 1'b0 || step_err8 !== 1'b0) begin
            errors++;
            $display("FAIL w8_idle: b_reg=%h out_valid=%b step_err=%b, required 00/0/0",
                     b_reg8, out_valid8, step_err8);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        g         = '0;
        in_valid8 = 1'b0;
        g8        = '0;
        model_reset();
        #12;
        test_reset();
        test_comb_exhaustive();
        test_registered();
        test_async_reset();
        test_step_check();
        test_back_to_back();
        test_width8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
